// File: rtl/issue_ctrl_pkg.sv
// Shared opcode, ALUOp and control-bundle definitions for the single-issue
// ALU sequencing controller.
package issue_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SET   = 6'b000001;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_write;
  } ctrl_t;

endpackage

// File: rtl/issue_decode.sv
// Combinational decode of one instruction word into control lines,
// destination register, second-source usage and an illegal-opcode flag.
module issue_decode
  import issue_ctrl_pkg::*;
(
  input  logic [31:0] instn,
  output ctrl_t       ctrl,
  output logic [4:0]  waddr,
  output logic        uses_rt,
  output logic        illegal
);

  logic unused_bits;
  assign unused_bits = ^{instn[25:21], instn[10:0]};

  always_comb begin
    ctrl    = '0;
    uses_rt = 1'b0;
    illegal = 1'b0;
    case (instn[31:26])
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
        ctrl.reg_write = 1'b1;
        uses_rt        = 1'b1;
      end
      OP_ADDI, OP_SET: begin
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      default: begin
        // Undefined opcodes flow as a non-writing NOP
        ctrl.alu_op = ALUOP_FUNCT;
        illegal     = 1'b1;
      end
    endcase
    waddr = ctrl.reg_dst ? instn[15:11] : instn[20:16];
  end

endmodule

// File: rtl/issue_ctrl.sv
// ID/EX/WB sequencing for the single-issue ALU datapath: valid/ready intake,
// one-cycle RAW stall against EX, retire and stall counters.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instn_valid,
  input  logic [31:0]      instn,
  output logic             instn_ready,
  output logic             ex_valid,
  output logic             ex_RegDst,
  output logic [1:0]       ex_ALUOp,
  output logic             ex_ALUSrc,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_waddr,
  output logic             wb_valid,
  output logic             wb_RegWrite,
  output logic [4:0]       wb_waddr,
  output logic             illegal,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             id_valid_q, id_valid_d;
  logic [31:0]      id_instn_q, id_instn_d;
  logic             ex_valid_q, ex_valid_d;
  ctrl_t            ex_ctrl_q, ex_ctrl_d;
  logic [4:0]       ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_waddr_q, ex_waddr_d;
  logic             illegal_q, illegal_d;
  logic             wb_valid_q, wb_valid_d, wb_reg_write_q, wb_reg_write_d;
  logic [4:0]       wb_waddr_q, wb_waddr_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d, stall_cnt_q, stall_cnt_d;

  ctrl_t      id_ctrl;
  logic [4:0] id_waddr, id_rs, id_rt;
  logic       id_uses_rt, id_illegal, hazard, id_advance, accept;

  issue_decode u_decode (
    .instn   (id_instn_q),
    .ctrl    (id_ctrl),
    .waddr   (id_waddr),
    .uses_rt (id_uses_rt),
    .illegal (id_illegal)
  );

  always_comb begin
    id_rs = id_instn_q[25:21];
    id_rt = id_instn_q[20:16];
    // No WB->ID check: the register file writes before it is read
    hazard = id_valid_q & ex_valid_q & ex_ctrl_q.reg_write & (ex_waddr_q != '0) &
             ((ex_waddr_q == id_rs) | (id_uses_rt & (ex_waddr_q == id_rt)));
    id_advance  = id_valid_q & ~hazard;
    instn_ready = ~id_valid_q | id_advance;
    accept      = instn_valid & instn_ready;

    id_valid_d = id_valid_q;
    id_instn_d = id_instn_q;
    if (accept) begin
      id_valid_d = 1'b1;
      id_instn_d = instn;
    end else if (id_advance) begin
      id_valid_d = 1'b0;
      id_instn_d = '0;
    end

    ex_valid_d = 1'b0;
    ex_ctrl_d  = '0;
    ex_rs_d    = '0;
    ex_rt_d    = '0;
    ex_waddr_d = '0;
    illegal_d  = 1'b0;
    if (id_advance) begin
      ex_valid_d = 1'b1;
      ex_ctrl_d  = id_ctrl;
      ex_rs_d    = id_rs;
      ex_rt_d    = id_rt;
      ex_waddr_d = id_waddr;
      illegal_d  = id_illegal;
    end

    wb_valid_d     = ex_valid_q;
    wb_reg_write_d = ex_valid_q & ex_ctrl_q.reg_write;
    wb_waddr_d     = ex_waddr_q;

    retire_cnt_d = ex_valid_q ? retire_cnt_q + CNT_ONE : retire_cnt_q;
    stall_cnt_d  = (hazard && stall_cnt_q != '1) ? stall_cnt_q + CNT_ONE : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_q     <= 1'b0;
      id_instn_q     <= '0;
      ex_valid_q     <= 1'b0;
      ex_ctrl_q      <= '0;
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
      ex_waddr_q     <= '0;
      illegal_q      <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_waddr_q     <= '0;
      retire_cnt_q   <= '0;
      stall_cnt_q    <= '0;
    end else begin
      id_valid_q     <= id_valid_d;
      id_instn_q     <= id_instn_d;
      ex_valid_q     <= ex_valid_d;
      ex_ctrl_q      <= ex_ctrl_d;
      ex_rs_q        <= ex_rs_d;
      ex_rt_q        <= ex_rt_d;
      ex_waddr_q     <= ex_waddr_d;
      illegal_q      <= illegal_d;
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_waddr_q     <= wb_waddr_d;
      retire_cnt_q   <= retire_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_RegDst   = ex_ctrl_q.reg_dst;
  assign ex_ALUOp    = ex_ctrl_q.alu_op;
  assign ex_ALUSrc   = ex_ctrl_q.alu_src;
  assign ex_rs       = ex_rs_q;
  assign ex_rt       = ex_rt_q;
  assign ex_waddr    = ex_waddr_q;
  assign wb_valid    = wb_valid_q;
  assign wb_RegWrite = wb_reg_write_q;
  assign wb_waddr    = wb_waddr_q;
  assign illegal     = illegal_q;
  assign retire_cnt  = retire_cnt_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed vector table, hand-written corner sequences,
// and randomized traffic against an instruction-level reference model.
module tb_issue_ctrl;

  localparam int unsigned CNT_W = 4;
  localparam int CNT_MOD = 1 << CNT_W;
  localparam int CNT_MAX = CNT_MOD - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             instn_valid = 1'b1;
  logic [31:0]      instn = 32'h2001_0005;
  logic             instn_ready, ex_valid, ex_RegDst, ex_ALUSrc;
  logic [1:0]       ex_ALUOp;
  logic [4:0]       ex_rs, ex_rt, ex_waddr, wb_waddr;
  logic             wb_valid, wb_RegWrite, illegal;
  logic [CNT_W-1:0] retire_cnt, stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  issue_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .instn_valid(instn_valid), .instn(instn),
    .instn_ready(instn_ready), .ex_valid(ex_valid), .ex_RegDst(ex_RegDst),
    .ex_ALUOp(ex_ALUOp), .ex_ALUSrc(ex_ALUSrc), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_waddr(ex_waddr), .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite),
    .wb_waddr(wb_waddr), .illegal(illegal), .retire_cnt(retire_cnt),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: instruction slots, decoded on demand
  typedef struct packed { logic v; logic [31:0] i; } slot_t;
  slot_t m_id, m_ex, m_wb;
  int    m_ret, m_st;

  function automatic logic f_rtype(input logic [31:0] i);
    return i[31:26] == 6'd0;
  endfunction
  function automatic logic f_legal(input logic [31:0] i);
    return i[31:26] == 6'd0 || i[31:26] == 6'd8 || i[31:26] == 6'd1;
  endfunction
  function automatic logic [4:0] f_waddr(input logic [31:0] i);
    return f_rtype(i) ? i[15:11] : i[20:16];
  endfunction
  function automatic logic m_hazard();
    logic [4:0] w;
    w = f_waddr(m_ex.i);
    return m_id.v && m_ex.v && f_legal(m_ex.i) && w != 5'd0 &&
           (w == m_id.i[25:21] || (f_rtype(m_id.i) && w == m_id.i[20:16]));
  endfunction

  task automatic model_clear();
    m_id = '0; m_ex = '0; m_wb = '0; m_ret = 0; m_st = 0;
  endtask

  task automatic model_step(input logic r, input logic v, input logic [31:0] i);
    logic hz, adv;
    if (r) begin
      model_clear();
    end else begin
      hz  = m_hazard();
      adv = m_id.v && !hz;
      m_ret = (m_ret + int'(m_ex.v)) % CNT_MOD;
      if (hz && m_st < CNT_MAX) m_st++;
      m_wb = m_ex;
      m_ex = adv ? m_id : '0;
      if (v && (!m_id.v || adv)) m_id = '{1'b1, i};
      else if (adv) m_id = '0;
    end
  endtask

  task automatic model_check();
    logic legal_ex, alu_add;
    legal_ex = f_legal(m_ex.i);
    alu_add  = legal_ex && !f_rtype(m_ex.i);
    chk("m_ready",   32'(instn_ready), 32'(!m_id.v || !m_hazard()));
    chk("m_ex_valid", 32'(ex_valid),   32'(m_ex.v));
    chk("m_ex_regdst", 32'(ex_RegDst), 32'(m_ex.v && f_rtype(m_ex.i)));
    chk("m_ex_aluop", 32'(ex_ALUOp),   !m_ex.v ? 32'd0 : (alu_add ? 32'd0 : 32'd2));
    chk("m_ex_alusrc", 32'(ex_ALUSrc), 32'(m_ex.v && alu_add));
    chk("m_ex_rs",   32'(ex_rs),       m_ex.v ? 32'(m_ex.i[25:21]) : 32'd0);
    chk("m_ex_rt",   32'(ex_rt),       m_ex.v ? 32'(m_ex.i[20:16]) : 32'd0);
    chk("m_ex_waddr", 32'(ex_waddr),   m_ex.v ? 32'(f_waddr(m_ex.i)) : 32'd0);
    chk("m_illegal", 32'(illegal),     32'(m_ex.v && !legal_ex));
    chk("m_wb_valid", 32'(wb_valid),   32'(m_wb.v));
    chk("m_wb_regwrite", 32'(wb_RegWrite), 32'(m_wb.v && f_legal(m_wb.i)));
    chk("m_wb_waddr", 32'(wb_waddr),   m_wb.v ? 32'(f_waddr(m_wb.i)) : 32'd0);
    chk("m_retire",  32'(retire_cnt),  32'(m_ret));
    chk("m_stall",   32'(stall_cnt),   32'(m_st));
  endtask

  // ---------------- directed vector table
  typedef struct {
    logic v; logic [31:0] i;
    logic rdy, exv; logic [4:0] exw; logic ill;
    logic wbv, wbrw; logic [4:0] wbw;
    int ret, st;
  } vec_t;
  vec_t tbl[15];

  function automatic vec_t mk(input logic v, input logic [31:0] i, input logic rdy,
                              input logic exv, input logic [4:0] exw, input logic ill,
                              input logic wbv, input logic wbrw, input logic [4:0] wbw,
                              input int ret, input int st);
    vec_t r;
    r.v = v; r.i = i; r.rdy = rdy; r.exv = exv; r.exw = exw; r.ill = ill;
    r.wbv = wbv; r.wbrw = wbrw; r.wbw = wbw; r.ret = ret; r.st = st;
    return r;
  endfunction

  // one cycle: drive at posedge+1, wait for the next posedge+1
  task automatic cyc(input logic r, input logic v, input logic [31:0] i);
    rst = r; instn_valid = v; instn = i;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] i);
    int n;
    n = 0;
    rst = 1'b0; instn_valid = 1'b1; instn = i;
    while (!instn_ready && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_accept_within_bound", 32'(n < 8), 32'd1);
    @(posedge clk); #1;
    instn_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held two cycles with instn_valid asserted
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_ex_ctrl", 32'({ex_RegDst, ex_ALUOp, ex_ALUSrc}), 32'd0);
    chk("rst_ex_regs", 32'({ex_rs, ex_rt, ex_waddr}), 32'd0);
    chk("rst_wb", 32'({wb_valid, wb_RegWrite, wb_waddr}), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_counters", 32'({retire_cnt, stall_cnt}), 32'd0);
    rst = 1'b0; instn_valid = 1'b0; #1;
    chk("ready_after_rst", 32'(instn_ready), 32'd1);

    //             v  instn          rdy exv exw ill wbv wbrw wbw ret st
    tbl[0]  = mk(1, 32'h2001_0005, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 32'h2002_0007, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 32'h0,         1, 1, 1, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 32'h0,         1, 1, 2, 0, 1, 1, 1, 1, 0);
    tbl[4]  = mk(1, 32'h2001_0005, 1, 0, 0, 0, 1, 1, 2, 2, 0);
    tbl[5]  = mk(1, 32'h0022_1820, 1, 0, 0, 0, 0, 0, 0, 2, 0);
    tbl[6]  = mk(1, 32'h2002_0007, 0, 1, 1, 0, 0, 0, 0, 2, 0);
    tbl[7]  = mk(1, 32'h2002_0007, 1, 0, 0, 0, 1, 1, 1, 3, 1);
    tbl[8]  = mk(1, 32'h2000_0005, 1, 1, 3, 0, 0, 0, 0, 3, 1);
    tbl[9]  = mk(1, 32'h0000_2020, 1, 1, 2, 0, 1, 1, 3, 4, 1);
    tbl[10] = mk(1, 32'hFC00_0000, 1, 1, 0, 0, 1, 1, 2, 5, 1);
    tbl[11] = mk(0, 32'h0,         1, 1, 4, 0, 1, 1, 0, 6, 1);
    tbl[12] = mk(0, 32'h0,         1, 1, 0, 1, 1, 1, 4, 7, 1);
    tbl[13] = mk(0, 32'h0,         1, 0, 0, 0, 1, 0, 0, 8, 1);
    tbl[14] = mk(0, 32'h0,         1, 0, 0, 0, 0, 0, 0, 8, 1);

    for (int k = 0; k < 15; k++) begin
      instn_valid = tbl[k].v; instn = tbl[k].i;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", k),    32'(instn_ready), 32'(tbl[k].rdy));
      chk($sformatf("tbl%0d_ex_valid", k), 32'(ex_valid),    32'(tbl[k].exv));
      chk($sformatf("tbl%0d_ex_waddr", k), 32'(ex_waddr),    32'(tbl[k].exw));
      chk($sformatf("tbl%0d_illegal", k),  32'(illegal),     32'(tbl[k].ill));
      chk($sformatf("tbl%0d_wb_valid", k), 32'(wb_valid),    32'(tbl[k].wbv));
      chk($sformatf("tbl%0d_wb_rw", k),    32'(wb_RegWrite), 32'(tbl[k].wbrw));
      chk($sformatf("tbl%0d_wb_waddr", k), 32'(wb_waddr),    32'(tbl[k].wbw));
      chk($sformatf("tbl%0d_retire", k),   32'(retire_cnt),  32'(tbl[k].ret));
      chk($sformatf("tbl%0d_stall", k),    32'(stall_cnt),   32'(tbl[k].st));
      @(posedge clk); #1;
    end

    // reset while an instruction sits in EX: it must never reach WB
    cyc(1'b0, 1'b1, 32'h2005_0005);
    cyc(1'b0, 1'b0, 32'h0);
    chk("mid_ex_loaded", 32'({ex_valid, ex_waddr}), 32'({1'b1, 5'd5}));
    cyc(1'b1, 1'b1, 32'h2006_0005);
    chk("mid_rst_ex", 32'(ex_valid), 32'd0);
    chk("mid_rst_wb", 32'(wb_valid), 32'd0);
    chk("mid_rst_cnt", 32'({retire_cnt, stall_cnt}), 32'd0);
    cyc(1'b0, 1'b0, 32'h0);
    chk("mid_rst_wb_next", 32'(wb_valid), 32'd0);
    chk("mid_rst_nothing_accepted", 32'(ex_valid), 32'd0);

    // 17 back-to-back independent retirements: counter wraps to 1
    for (int k = 0; k < 17; k++) begin
      logic [31:0] w;
      w = {6'd8, 5'd0, 5'(k % 31 + 1), 16'd0};
      chk("wrap_ready", 32'(instn_ready), 32'd1);
      cyc(1'b0, 1'b1, w);
    end
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 32'h0);
    chk("retire_wrap", 32'(retire_cnt), 32'd1);
    chk("wrap_no_stall", 32'(stall_cnt), 32'd0);

    // 16 RAW pairs: stall counter saturates at all-ones
    cyc(1'b1, 1'b0, 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      send(32'h2001_0005);
      send(32'h2022_0000);
    end
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 32'h0);
    chk("stall_saturate", 32'(stall_cnt), 32'(CNT_MAX));
    chk("retire_after_32", 32'(retire_cnt), 32'(32 % CNT_MOD));

    // randomized traffic against the reference model
    cyc(1'b1, 1'b0, 32'h0);
    model_clear();
    for (int c = 0; c < 2000; c++) begin
      logic [5:0] op;
      int sel;
      sel = int'($urandom_range(0, 5));
      case (sel)
        0, 1: op = 6'd0;
        2:    op = 6'd8;
        3:    op = 6'd1;
        4:    op = 6'($urandom);
        default: op = 6'h3F;
      endcase
      rst = ($urandom_range(0, 49) == 0);
      instn_valid = ($urandom_range(0, 3) != 0);
      instn = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 11'($urandom)};
      @(negedge clk);
      model_check();
      @(posedge clk);
      model_step(rst, instn_valid, instn);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- Sequencing controller for the single-issue ALU datapath (R-type, ADDI, SET).
- Accepts 32-bit instructions over a valid/ready handshake and holds each one in an ID register.
- Decodes control lines and carries them through registered EX and WB stages.
- Stalls ID for one cycle on a read-after-write hazard against EX, and keeps retire and stall counters.

Parameters:
- CNT_W, 16: width of retire_cnt and stall_cnt.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- instn_valid  in  1  upstream instruction valid.
- instn  in  32  instruction; opcode [31:26], rs [25:21], rt [20:16], rd [15:11].
- instn_ready  out  1  ID slot can accept an instruction.
- ex_valid  out  1  EX stage holds a real instruction (not a bubble).
- ex_RegDst  out  1  EX control line.
- ex_ALUOp  out  2  EX control line.
- ex_ALUSrc  out  1  EX control line.
- ex_rs  out  5  EX source register.
- ex_rt  out  5  EX source register.
- ex_waddr  out  5  EX destination register.
- wb_valid  out  1  WB stage holds a real instruction.
- wb_RegWrite  out  1  register-file write enable; already gated by wb_valid.
- wb_waddr  out  5  register-file write address.
- illegal  out  1  one-cycle pulse when an undefined opcode advances ID->EX.
- retire_cnt  out  CNT_W  count of valid instructions that have entered WB.
- stall_cnt  out  CNT_W  count of hazard stall cycles.

Behaviour:
- Reset: all outputs and stage registers are 0, so every stage is empty.
- Reset has priority over every other event, including mid-stream. In-flight instructions are discarded, and nothing is accepted on the reset cycle.
- Decode table:
  - 000000 (R-type): RegDst=1, ALUOp=10, ALUSrc=0, RegWrite=1, reads rs and rt.
  - 001000 (ADDI) and 000001 (SET): RegDst=0, ALUOp=00, ALUSrc=1, RegWrite=1, read rs only.
  - Any other opcode: RegDst=0, ALUOp=10, ALUSrc=0, RegWrite=0. Treated as a NOP that still flows with valid=1.
- waddr = RegDst ? rd : rt.
- Hazard = id_valid & ex_valid & ex_RegWrite & (ex_waddr != 0) & (ex_waddr == id_rs | (id_is_Rtype & ex_waddr == id_rt)).
  - WB->ID hazards are not stalled: the register file is write-first.
- id_advance = id_valid & !hazard.
- instn_ready = !id_valid | id_advance. It is combinational, with no dependence on instn_valid.
- The ID register loads on instn_valid & instn_ready; otherwise it clears when advancing and holds while stalled.
- EX loads the decoded ID contents on id_advance; otherwise it loads a bubble (ex_valid=0, all controls 0).
- WB always loads from EX; downstream never stalls.
- Latency: handshake at edge k -> ID at k, EX outputs valid after k+1, WB after k+2 when there is no hazard. A hazard adds exactly one cycle.
- Throughput: one instruction per cycle with no hazards, including continuous back-to-back acceptance.
- retire_cnt: +1 on each edge that loads WB with a valid instruction (illegal ones included); wraps modulo 2^CNT_W.
- stall_cnt: +1 on each hazard cycle; saturates at all-ones.
- Simultaneous ID advance and new accept is allowed in the same cycle.
- instn must be stable only while it is being accepted.

Decomposition:
- Shared package holds:
  - opcode localparams OP_RTYPE, OP_ADDI, OP_SET;
  - ALUOp encodings ALUOP_ADD=00, ALUOP_FUNCT=10;
  - the ctrl_t bundle {RegDst, ALUOp, ALUSrc, RegWrite}.
- One natural sub-module: issue_decode, purely combinational (instn -> ctrl_t, waddr, uses_rt, illegal).
- Pipeline registers, hazard logic and counters stay in issue_ctrl.

Test Plan:
- Reset check: hold rst for 2 cycles with instn_valid=1 -> all outputs 0 after reset; instn_ready=1 on the first non-reset cycle.
- Back-to-back independent pair: ADDI r1,r0,5 (0x20010005) then ADDI r2,r0,7 (0x20020007), no gaps -> no stall; wb_waddr=1 then 2 on consecutive cycles; retire_cnt=2.
- RAW stall: ADDI r1 (0x20010005) then R-type add r3,r1,r2 (0x00221820) -> instn_ready=0 for one cycle; one ex_valid=0 bubble; stall_cnt=1; add reaches WB with wb_waddr=3 one cycle late.
- r0 exemption: ADDI r0 (0x20000005) then R-type reading r0 (0x00002020) -> no stall; stall_cnt=0.
- Illegal opcode: 0xFC000000 -> illegal pulses for one cycle; wb_valid=1 with wb_RegWrite=0; retire_cnt increments.
- Reset mid-stream and counter behaviour with CNT_W=4:
  - rst asserted with an instruction in EX -> it never reaches WB;
  - 17 retirements -> retire_cnt=1 (wraps);
  - 16 stalls -> stall_cnt=15 (saturates).
